if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage pipelined ARM-subset CPU.
//   - Holds the program counter (PC) and drives it to instruction memory as the fetch address.
//   - Selects the next PC: sequential PC+4, or a branch target when commanded.
//   - Registers the fetched PC/instruction pair into the IF/ID pipeline register for decode.

---
 rtl/if_stage.sv | 61 ++++++
 tb/tb_if_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, drives it to instruction memory as
// the fetch address, picks the next PC (sequential or branch redirect) and
// registers the fetched PC/instruction pair into the IF/ID pipeline register.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset (asserted when 0)
//   pc_write_en         1 = redirect PC to branch_target_addr, 0 = PC+4
//   branch_target_addr  redirect address, word-aligned on load
//   imem_addr           fetch address (the current PC, no added latency)
//   imem_rdata          instruction word returned combinationally for imem_addr
//   pc_out_ifid         IF/ID: PC of the latched instruction
//   instr_out_ifid      IF/ID: latched instruction word
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'hE600_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_write_en,
   input  logic [31:0] branch_target_addr,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out_ifid,
   output logic [31:0] instr_out_ifid
);

   localparam int unsigned XLEN       = 32;
   localparam int unsigned ALIGN_BITS = 2;
   localparam int unsigned INSTR_SIZE = 4;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next_c;

   // Next-PC select; branch targets are forced onto a word boundary and the
   // sequential increment wraps naturally modulo 2^32.
   always_comb begin
      pc_next_c = pc + XLEN'(INSTR_SIZE);
      if (pc_write_en) begin
         pc_next_c = {branch_target_addr[XLEN-1:ALIGN_BITS], ALIGN_BITS'(0)};
      end
   end

   // PC and IF/ID register; IF/ID captures the pre-update PC and the word
   // fetched for it, so the pipeline register lags imem_addr by one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc             <= RESET_PC;
         pc_out_ifid    <= RESET_PC;
         instr_out_ifid <= NOP_INSTR;
      end else begin
         pc             <= pc_next_c;
         pc_out_ifid    <= pc;
         instr_out_ifid <= imem_rdata;
      end
   end

   // Fetch address is the PC flop itself.
   assign imem_addr = pc;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with constant
// expectations, then randomized redirects and resets against a fetch model.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'hE600_0000;

   logic        clk;
   logic        reset;
   logic        pc_write_en;
   logic [31:0] branch_target_addr;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_out_ifid;
   logic [31:0] instr_out_ifid;

   int total;
   int bad;

   // Instruction memory contents: small program table, or a hashed pattern.
   logic hash_mode;

   // Reference model state: PC and IF/ID pair as seen by the program.
   logic [31:0] m_pc;
   logic [31:0] m_ifid_pc;
   logic [31:0] m_ifid_instr;

   if_stage dut (
      .clk                (clk),
      .reset              (reset),
      .pc_write_en        (pc_write_en),
      .branch_target_addr (branch_target_addr),
      .imem_addr          (imem_addr),
      .imem_rdata         (imem_rdata),
      .pc_out_ifid        (pc_out_ifid),
      .instr_out_ifid     (instr_out_ifid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem_f(input logic [31:0] a, input logic hm);
      if (hm) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      case (a)
         32'h0:   return 32'hE680_100A;
         32'h4:   return 32'hE680_2014;
         32'h8:   return 32'hE021_3000;
         32'hC:   return 32'hE923_4004;
         default: return NOP;
      endcase
   endfunction

   always_comb imem_rdata = imem_f(imem_addr, hash_mode);

   task automatic model_reset();
      m_pc         = 32'h0;
      m_ifid_pc    = 32'h0;
      m_ifid_instr = NOP;
   endtask

   // Drive one cycle's controls, take one rising edge and advance the model.
   task automatic tick(input logic we, input logic [31:0] tgt);
      logic [31:0] cur;
      pc_write_en        = we;
      branch_target_addr = tgt;
      cur = m_pc;
      @(posedge clk);
      #1;
      m_ifid_pc    = cur;
      m_ifid_instr = imem_f(cur, hash_mode);
      m_pc         = we ? (tgt & ~32'h3) : cur + 32'd4;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (imem_addr !== 32'h0 || pc_out_ifid !== 32'h0 || instr_out_ifid !== NOP) begin
         bad++;
         $display("FAIL reset_edge: addr=%h pc=%h instr=%h want 0/0/%h",
                  imem_addr, pc_out_ifid, instr_out_ifid, NOP);
      end
      @(negedge clk);
      #1;
      total++;
      if (imem_addr !== 32'h0 || pc_out_ifid !== 32'h0 || instr_out_ifid !== NOP) begin
         bad++;
         $display("FAIL reset_between: addr=%h pc=%h instr=%h want 0/0/%h",
                  imem_addr, pc_out_ifid, instr_out_ifid, NOP);
      end
      reset = 1'b1;
      model_reset();
      #1;
      total++;
      if (imem_addr !== 32'h0) begin
         bad++;
         $display("FAIL release_addr: addr=%h want 0", imem_addr);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_addr [3];
      logic [31:0] exp_pc   [3];
      logic [31:0] exp_ins  [3];
      exp_addr = '{32'h4, 32'h8, 32'hC};
      exp_pc   = '{32'h0, 32'h4, 32'h8};
      exp_ins  = '{32'hE680_100A, 32'hE680_2014, 32'hE021_3000};
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 32'hDEAD_BEEF);
         total++;
         if (imem_addr !== exp_addr[i] || pc_out_ifid !== exp_pc[i] ||
             instr_out_ifid !== exp_ins[i]) begin
            bad++;
            $display("FAIL seq_%0d: addr=%h pc=%h instr=%h want %h/%h/%h", i,
                     imem_addr, pc_out_ifid, instr_out_ifid,
                     exp_addr[i], exp_pc[i], exp_ins[i]);
         end
      end
   endtask

   task automatic test_branch();
      tick(1'b1, 32'h20);
      total++;
      if (imem_addr !== 32'h20 || pc_out_ifid !== 32'hC || instr_out_ifid !== 32'hE923_4004) begin
         bad++;
         $display("FAIL branch_edge: addr=%h pc=%h instr=%h want 20/c/e9234004",
                  imem_addr, pc_out_ifid, instr_out_ifid);
      end
      tick(1'b0, 32'h0);
      total++;
      if (imem_addr !== 32'h24 || pc_out_ifid !== 32'h20 || instr_out_ifid !== NOP) begin
         bad++;
         $display("FAIL branch_next: addr=%h pc=%h instr=%h want 24/20/%h",
                  imem_addr, pc_out_ifid, instr_out_ifid, NOP);
      end
   endtask

   task automatic test_post_branch();
      tick(1'b0, 32'h100);
      total++;
      if (imem_addr !== 32'h28 || pc_out_ifid !== 32'h24) begin
         bad++;
         $display("FAIL post_branch: addr=%h pc=%h want 28/24", imem_addr, pc_out_ifid);
      end
   endtask

   task automatic test_async_reset();
      #2;
      reset = 1'b0;
      #1;
      total++;
      if (imem_addr !== 32'h0 || pc_out_ifid !== 32'h0 || instr_out_ifid !== NOP) begin
         bad++;
         $display("FAIL async_reset: addr=%h pc=%h instr=%h want 0/0/%h",
                  imem_addr, pc_out_ifid, instr_out_ifid, NOP);
      end
      model_reset();
      #2;
      reset = 1'b1;
   endtask

   task automatic test_align_wrap();
      tick(1'b1, 32'h23);
      total++;
      if (imem_addr !== 32'h20) begin
         bad++;
         $display("FAIL align: addr=%h want 20", imem_addr);
      end
      tick(1'b1, 32'hFFFF_FFFF);
      total++;
      if (imem_addr !== 32'hFFFF_FFFC || pc_out_ifid !== 32'h20) begin
         bad++;
         $display("FAIL align_top: addr=%h pc=%h want fffffffc/20", imem_addr, pc_out_ifid);
      end
      tick(1'b0, 32'h0);
      total++;
      if (imem_addr !== 32'h0 || pc_out_ifid !== 32'hFFFF_FFFC || instr_out_ifid !== NOP) begin
         bad++;
         $display("FAIL wrap: addr=%h pc=%h instr=%h want 0/fffffffc/%h",
                  imem_addr, pc_out_ifid, instr_out_ifid, NOP);
      end
   endtask

   task automatic test_random();
      logic        we;
      logic [31:0] tgt;
      hash_mode = 1'b1;
      for (int i = 0; i < 300; i++) begin
         we  = ($urandom_range(0, 3) == 0);
         tgt = $urandom;
         tick(we, tgt);
         total++;
         if (imem_addr !== m_pc || pc_out_ifid !== m_ifid_pc || instr_out_ifid !== m_ifid_instr) begin
            bad++;
            $display("FAIL rand_%0d: addr=%h pc=%h instr=%h want %h/%h/%h", i,
                     imem_addr, pc_out_ifid, instr_out_ifid, m_pc, m_ifid_pc, m_ifid_instr);
         end
         if ($urandom_range(0, 39) == 0) begin
            #2;
            reset = 1'b0;
            #1;
            model_reset();
            total++;
            if (imem_addr !== m_pc || pc_out_ifid !== m_ifid_pc || instr_out_ifid !== m_ifid_instr) begin
               bad++;
               $display("FAIL rand_reset_%0d: addr=%h pc=%h instr=%h want %h/%h/%h", i,
                        imem_addr, pc_out_ifid, instr_out_ifid, m_pc, m_ifid_pc, m_ifid_instr);
            end
            #2;
            reset = 1'b1;
         end
      end
   endtask

   initial begin
      total              = 0;
      bad                = 0;
      hash_mode          = 1'b0;
      reset              = 1'b0;
      pc_write_en        = 1'b0;
      branch_target_addr = 32'h0;
      model_reset();
      test_reset();
      test_sequential();
      test_branch();
      test_post_branch();
      test_async_reset();
      test_align_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
